// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scan driver: digit count,
// "all off" patterns and the hex-to-segment lookup table.
package display_pkg;

  localparam int NDIG = 4;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}, indexed by nibble.
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7_encode.sv
// Combinational nibble + decimal point to active-low segment pattern
// {dp,g,f,e,d,c,b,a}.
module hex7_encode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, ~HEX7[nibble]};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Data written by the core sits in a pending buffer and is only copied to the
// displayed buffer at a frame boundary, so a frame never mixes old and new digits.
module seg7_scan_driver
  import display_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter bit LZB_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        data_valid,
  input  logic        lzb,
  output logic [11:0] digits,
  output logic        frame_start,
  output logic        pending
);

  localparam int             PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0]  PS_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]   prescaler;
  logic [1:0]      idx;
  logic [15:0]     disp_reg;
  logic [15:0]     pend_reg;
  logic [3:0]      disp_dp;
  logic [3:0]      pend_dp;
  logic            tick;
  logic            commit;
  logic            lzb_on;
  logic [3:0]      nibble;
  logic            dp_bit;
  logic [7:0]      seg;
  logic [NDIG-1:0] blank;
  logic [11:0]     digits_next;

  assign tick   = (prescaler == PS_LAST);
  assign commit = tick && (idx == 2'd3) && pending;
  assign lzb_on = LZB_EN & lzb;

  // Slot timer and scan index; frame_start marks the 3->0 wrap one cycle late.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler   <= '0;
      idx         <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick ? '0 : prescaler + 1'b1;
      frame_start <= tick && (idx == 2'd3);
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Pending/display double buffer; a write coinciding with a commit stays pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_reg <= '0;
      pend_dp  <= '0;
      disp_reg <= '0;
      disp_dp  <= '0;
      pending  <= 1'b0;
    end else begin
      if (commit) begin
        disp_reg <= pend_reg;
        disp_dp  <= pend_dp;
      end
      if (data_valid) begin
        pend_reg <= data_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end else if (commit) begin
        pending  <= 1'b0;
      end
    end
  end

  // Leading-zero blanking mask: a digit blanks when it and all higher nibbles are zero.
  always_comb begin
    blank    = '0;
    blank[3] = lzb_on && (disp_reg[15:12] == 4'h0);
    blank[2] = blank[3] && (disp_reg[11:8] == 4'h0);
    blank[1] = blank[2] && (disp_reg[7:4] == 4'h0);
  end

  assign nibble = disp_reg[{idx, 2'b00} +: 4];
  assign dp_bit = disp_dp[idx];

  hex7_encode u_hex7_encode (
    .nibble (nibble),
    .dp     (dp_bit),
    .seg    (seg)
  );

  // Select the active anode and segment pattern for the current slot.
  always_comb begin
    digits_next = {AN_OFF, SEG_OFF};
    if (!blank[idx]) digits_next = {~(4'b0001 << idx), seg};
  end

  // Output register keeps the pad drivers glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) digits <= {AN_OFF, SEG_OFF};
    else        digits <= digits_next;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with CLK_DIV=4. Stimulus pushes
// hand-computed expectations tagged with the clock edge they belong to; the
// monitor samples on the falling edge and compares whatever is due.
module tb_seg7_scan_driver;

  localparam int K_DIG  = 0;
  localparam int K_PEND = 1;
  localparam int K_FS   = 2;

  // Edge counter value at the negedge where reset is released (edge B+1 is
  // the first post-reset edge), and the same for the mid-scan reset.
  localparam int B  = 3;
  localparam int B2 = B + 171;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        data_valid;
  logic        lzb;
  logic [11:0] digits;
  logic        frame_start;
  logic        pending;

  seg7_scan_driver #(.CLK_DIV(4), .LZB_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .data_valid  (data_valid),
    .lzb         (lzb),
    .digits      (digits),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    int          kind;
    logic [11:0] v;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [11:0] act;

  task automatic expect_at(input int c, input int kind, input logic [11:0] v, input string nm);
    exp_t e;
    e.c = c; e.kind = kind; e.v = v;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic expect_frame(input int c0, input logic [11:0] d0, input logic [11:0] d1,
                              input logic [11:0] d2, input logic [11:0] d3, input string nm);
    for (int j = 0; j < 16; j++) begin
      case (j / 4)
        0:       expect_at(c0 + j, K_DIG, d0, nm);
        1:       expect_at(c0 + j, K_DIG, d1, nm);
        2:       expect_at(c0 + j, K_DIG, d2, nm);
        default: expect_at(c0 + j, K_DIG, d3, nm);
      endcase
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input int k, input logic [15:0] d, input logic [3:0] dp);
    go_to(B + k - 1);
    data_in    = d;
    dp_in      = dp;
    data_valid = 1'b1;
    go_to(B + k);
    data_valid = 1'b0;
  endtask

  // Monitor: evaluate every expectation due at the current edge count.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].c <= cyc) begin
        case (sb_q[i].kind)
          K_DIG:   act = digits;
          K_PEND:  act = {11'd0, pending};
          default: act = {11'd0, frame_start};
        endcase
        n_checks++;
        if (sb_q[i].c < cyc) begin
          n_fail++;
          $display("FAIL %s: check for edge %0d skipped (now %0d)", nm_q[i], sb_q[i].c, cyc);
        end else if (act !== sb_q[i].v) begin
          n_fail++;
          $display("FAIL %s @edge %0d: got %h, expected %h", nm_q[i], cyc, act, sb_q[i].v);
        end
        sb_q.delete(i);
        nm_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; data_in = '0; dp_in = '0; data_valid = 1'b0; lzb = 1'b0;

    // Reset and idle frames
    for (int k = 1; k <= B; k++) begin
      expect_at(k, K_DIG,  12'hFFF, "reset_digits");
      expect_at(k, K_PEND, 12'h0,   "reset_pending");
      expect_at(k, K_FS,   12'h0,   "reset_frame_start");
    end
    expect_frame(B + 1,  12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, "idle_frame0");
    expect_frame(B + 17, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, "frame1_before_commit");
    expect_at(B + 15, K_FS, 12'h0, "fs_low_15");
    expect_at(B + 16, K_FS, 12'h1, "fs_pulse_16");
    expect_at(B + 17, K_FS, 12'h0, "fs_low_17");
    expect_at(B + 32, K_FS, 12'h1, "fs_pulse_32");

    // 12AF with dp on digit 0
    expect_at(B + 20, K_PEND, 12'h0, "pend_before_write");
    expect_at(B + 21, K_PEND, 12'h1, "pend_after_write");
    expect_at(B + 31, K_PEND, 12'h1, "pend_held");
    expect_at(B + 32, K_PEND, 12'h0, "pend_cleared");
    expect_frame(B + 33, 12'hE0E, 12'hD88, 12'hBA4, 12'h7F9, "frame_12AF");

    // 0000 then 5555 on the commit edge
    expect_frame(B + 49, 12'hE0E, 12'hD88, 12'hBA4, 12'h7F9, "frame3_hold");
    expect_at(B + 64, K_PEND, 12'h1, "pend_write_on_commit");
    expect_at(B + 64, K_FS,   12'h1, "fs_pulse_64");
    expect_at(B + 79, K_PEND, 12'h1, "pend_still_set");
    expect_at(B + 80, K_PEND, 12'h0, "pend_clear_80");
    expect_frame(B + 65, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, "frame_old_zero");
    expect_frame(B + 81, 12'hE92, 12'hD92, 12'hB92, 12'h792, "frame_5555");

    // Leading-zero blanking
    expect_frame(B + 97,  12'hEA4, 12'hD99, 12'hFFF, 12'hFFF, "lzb_0042");
    expect_frame(B + 113, 12'hEC0, 12'hFFF, 12'hFFF, 12'hFFF, "lzb_0000");
    expect_frame(B + 129, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, "nolzb_0000");

    // Back-to-back writes, last wins
    expect_at(B + 133, K_PEND, 12'h1, "pend_b2b");
    expect_frame(B + 145, 12'hEA4, 12'hDA4, 12'hBA4, 12'h7A4, "frame_2222");

    // Mid-scan reset at idx=2 with data pending
    for (int k = 161; k <= 169; k++)
      expect_at(B + k, K_DIG, (k <= 164) ? 12'hEA4 : ((k <= 168) ? 12'hDA4 : 12'hBA4), "frame10_pre_reset");
    expect_at(B + 169, K_PEND, 12'h1, "pend_before_reset");
    expect_at(B + 170, K_DIG,  12'hFFF, "midreset_digits");
    expect_at(B + 170, K_PEND, 12'h0,   "midreset_pending");
    expect_at(B + 170, K_FS,   12'h0,   "midreset_fs");
    expect_at(B + 171, K_DIG,  12'hFFF, "midreset_digits2");
    expect_frame(B2 + 1,  12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, "post_reset_frame0");
    expect_frame(B2 + 17, 12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0, "post_reset_frame1");
    expect_at(B2 + 1,  K_PEND, 12'h0, "post_reset_pend");
    expect_at(B2 + 16, K_PEND, 12'h0, "post_reset_pend_wrap");
    expect_at(B2 + 15, K_FS,   12'h0, "post_reset_fs_low");
    expect_at(B2 + 16, K_FS,   12'h1, "post_reset_fs_pulse");

    // Drive stimulus
    go_to(B);
    reset = 1'b1;
    wr(21, 16'h12AF, 4'b0001);
    wr(52, 16'h0000, 4'b0000);
    wr(64, 16'h5555, 4'b0000);
    go_to(B + 83);
    lzb = 1'b1;
    wr(84, 16'h0042, 4'b0000);
    wr(100, 16'h0000, 4'b0000);
    go_to(B + 128);
    lzb = 1'b0;
    wr(132, 16'h1111, 4'b0000);
    wr(133, 16'h2222, 4'b0000);
    wr(165, 16'h3333, 4'b0000);
    go_to(B + 169);
    reset = 1'b0;
    go_to(B2);
    reset = 1'b1;
    go_to(B2 + 34);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
